// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI control path (arbiter and spi_master users).
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package spi_ctrl_pkg;

  // Default bus widths, shared with spi_master instantiations
  localparam int DEF_ADDRWIDTH = 3;
  localparam int DEF_DATAWIDTH = 8;

  // Arbiter FSM state encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Ceiling log2, with a minimum of 1 so that index vectors are never zero-width
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side and spi_master-side signals of the SPI transfer arbiter.
// Latency: n/a (wiring only).
// Backpressure: req is level-held by each requester until its done pulse.
interface spi_xfer_arbiter_if
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           req_rw;
  logic [NUM_REQ*ADDRWIDTH-1:0] req_addr;
  logic [NUM_REQ*DATAWIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]           done;
  logic [DATAWIDTH-1:0]         rdata;
  logic                         err;
  logic                         busy;
  logic [NUM_REQ-1:0]           grant;
  logic                         m_enable;
  logic                         m_rw_en;
  logic [ADDRWIDTH-1:0]         m_address;
  logic [DATAWIDTH-1:0]         m_data_in;
  logic                         m_rw_ack;
  logic [DATAWIDTH-1:0]         m_data_out;

  // Arbiter view
  modport slave (
    input  req, req_rw, req_addr, req_wdata, m_rw_ack, m_data_out,
    output done, rdata, err, busy, grant, m_enable, m_rw_en, m_address, m_data_in
  );

  // Requester / spi_master view
  modport master (
    output req, req_rw, req_addr, req_wdata, m_rw_ack, m_data_out,
    input  done, rdata, err, busy, grant, m_enable, m_rw_en, m_address, m_data_in
  );
endinterface

// File: rtl/spi_rr_pick.sv
// Round-robin pick: first set req bit at index >= rr_ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; pick is all-zero when req is all-zero.
module spi_rr_pick
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      idx
);
  logic found;
  int   pos;

  // Scan from rr_ptr upward with an explicit wrap; the first hit wins
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos]) begin
        found     = 1'b1;
        pick[pos] = 1'b1;
        idx       = IW'(pos);
      end
    end
  end
endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one spi_master between NUM_REQ requesters with ack timeout.
// Latency: grant + m_enable 1 cycle after req sampled; done 1 cycle after ack/timeout.
// Backpressure: requests wait in IDLE; GAP holds off the next grant while m_rw_ack stays high.
module spi_xfer_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  spi_xfer_arbiter_if.slave bus
);
  localparam int IW = clog2(NUM_REQ);

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      idx;
  logic [7:0]         tcnt;
  logic [3:0]         gcnt;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;

  spi_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .idx    (pick_idx)
  );

  // Single FSM; m_address/m_data_in/m_rw_en registers double as the holding
  // registers, loaded once at grant and held until GAP is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      idx           <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      bus.done      <= '0;
      bus.rdata     <= '0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.grant     <= '0;
      bus.m_enable  <= 1'b0;
      bus.m_rw_en   <= 1'b0;
      bus.m_address <= '0;
      bus.m_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            idx           <= pick_idx;
            bus.grant     <= pick;
            bus.busy      <= 1'b1;
            bus.m_enable  <= 1'b1;
            bus.m_rw_en   <= bus.req_rw[pick_idx];
            bus.m_address <= bus.req_addr[pick_idx*ADDRWIDTH +: ADDRWIDTH];
            bus.m_data_in <= bus.req_wdata[pick_idx*DATAWIDTH +: DATAWIDTH];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.m_enable <= 1'b0;
          tcnt         <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          // Ack is tested first so it wins over a coincident timeout
          if (tcnt != 8'(TIMEOUT - 1)) tcnt <= tcnt + 8'd1;
          if (bus.m_rw_ack) begin
            bus.rdata     <= bus.m_rw_en ? '0 : bus.m_data_out;
            bus.err       <= 1'b0;
            bus.done[idx] <= 1'b1;
            state         <= DONE;
          end else if (tcnt == 8'(TIMEOUT - 1)) begin
            bus.rdata     <= '0;
            bus.err       <= 1'b1;
            bus.done[idx] <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.done <= '0;
          rr_ptr   <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
          gcnt     <= '0;
          state    <= GAP;
        end
        GAP: begin
          // A lingering ack stretches GAP so the next enable never overlaps it
          if (gcnt == 4'(GAP_CYCLES - 1) && !bus.m_rw_ack) begin
            bus.grant     <= '0;
            bus.busy      <= 1'b0;
            bus.m_rw_en   <= 1'b0;
            bus.m_address <= '0;
            bus.m_data_in <= '0;
            state         <= IDLE;
          end else if (gcnt != 4'(GAP_CYCLES - 1)) begin
            gcnt <= gcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a small spi_master ack model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_xfer_arbiter;
  localparam int NR = 4;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int GP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_arbiter_if #(.NUM_REQ(NR), .ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  spi_xfer_arbiter #(
    .NUM_REQ(NR), .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO), .GAP_CYCLES(GP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // spi_master model controls
  int         ack_dly = 0;      // 0 = never ack
  logic [7:0] ack_val = '0;
  int         pend    = 0;

  // monitor state
  int         en_cyc_q[$];
  logic [3:0] en_grant_q[$];
  logic [2:0] last_addr;
  logic [7:0] last_wd;
  logic       last_rw;
  logic       prev_en  = 1'b0;
  int         en_multi = 0;
  int         done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // spi_master: ack pulses for one cycle ack_dly cycles after the enable cycle
  initial begin
    bus.m_rw_ack   = 1'b0;
    bus.m_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_rw_ack) bus.m_rw_ack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.m_rw_ack   = 1'b1;
          bus.m_data_out = ack_val;
        end
      end
      if (bus.m_enable) pend = ack_dly;
    end
  end

  // Observe enables and done pulses away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (bus.m_enable) begin
        if (prev_en) en_multi++;
        en_cyc_q.push_back(cyc);
        en_grant_q.push_back(bus.grant);
        last_addr = bus.m_address;
        last_wd   = bus.m_data_in;
        last_rw   = bus.m_rw_en;
      end
      prev_en = bus.m_enable;
      if (|bus.done) done_cnt++;
    end
  end

  task automatic set_req(input int i, input logic rw, input logic [2:0] a, input logic [7:0] d);
    bus.req_rw[i]          = rw;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_done(output logic [3:0] d, output int at);
    bit seen;
    seen = 1'b0;
    d    = '0;
    at   = -1;
    for (int k = 0; k < 300; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (|bus.done) begin
          seen = 1'b1;
          d    = bus.done;
          at   = cyc;
        end
      end
    end
    if (!seen) chk("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_en"},    32'(bus.m_enable), 32'd0);
    chk({tag, "_rw"},    32'(bus.m_rw_en), 32'd0);
    chk({tag, "_addr"},  32'(bus.m_address), 32'd0);
    chk({tag, "_wd"},    32'(bus.m_data_in), 32'd0);
  endtask

  logic [3:0] d;
  int         at;
  int         e;
  int         prev_e;
  int         dc;
  bit         en_seen;

  initial begin
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    // single write, ack 10 cycles after enable -> done 11 cycles after enable
    set_req(0, 1'b1, 3'd3, 8'hA5);
    ack_dly = 10; ack_val = 8'hFF;
    bus.req = 4'b0001;
    wait_done(d, at);
    e = en_cyc_q[$];
    chk("wr_done", 32'(d), 32'h1);
    chk("wr_err", 32'(bus.err), 32'd0);
    chk("wr_rdata", 32'(bus.rdata), 32'd0);
    chk("wr_grant", 32'(bus.grant), 32'h1);
    chk("wr_busy", 32'(bus.busy), 32'd1);
    chk("wr_lat", 32'(at - e), 32'd11);
    chk("wr_addr", 32'(last_addr), 32'd3);
    chk("wr_wd", 32'(last_wd), 32'hA5);
    chk("wr_rw", 32'(last_rw), 32'd1);
    bus.req = '0;
    repeat (5) @(negedge clk);
    chk("wr_idle_busy", 32'(bus.busy), 32'd0);
    chk("wr_idle_grant", 32'(bus.grant), 32'd0);
    chk("wr_idle_addr", 32'(bus.m_address), 32'd0);
    chk("wr_idle_wd", 32'(bus.m_data_in), 32'd0);
    chk("wr_idle_rw", 32'(bus.m_rw_en), 32'd0);

    // single read from requester 2
    set_req(2, 1'b0, 3'd5, 8'h11);
    ack_dly = 3; ack_val = 8'h3C;
    bus.req = 4'b0100;
    wait_done(d, at);
    e = en_cyc_q[$];
    chk("rd_done", 32'(d), 32'h4);
    chk("rd_rdata", 32'(bus.rdata), 32'h3C);
    chk("rd_err", 32'(bus.err), 32'd0);
    chk("rd_lat", 32'(at - e), 32'd4);
    chk("rd_addr", 32'(last_addr), 32'd5);
    chk("rd_rw", 32'(last_rw), 32'd0);
    bus.req = '0;
    repeat (5) @(negedge clk);
    chk("rd_rdata_hold", 32'(bus.rdata), 32'h3C);

    // timeout: no ack, done 64 cycles after entering WAIT
    set_req(1, 1'b0, 3'd2, 8'h00);
    ack_dly = 0;
    bus.req = 4'b0010;
    wait_done(d, at);
    e = en_cyc_q[$];
    chk("to_done", 32'(d), 32'h2);
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_rdata", 32'(bus.rdata), 32'd0);
    chk("to_lat", 32'(at - e), 32'(TO + 1));
    bus.req = '0;
    repeat (5) @(negedge clk);
    set_req(3, 1'b1, 3'd7, 8'h5E);
    ack_dly = 1;
    bus.req = 4'b1000;
    wait_done(d, at);
    e = en_cyc_q[$];
    chk("post_to_done", 32'(d), 32'h8);
    chk("post_to_err", 32'(bus.err), 32'd0);
    chk("post_to_lat", 32'(at - e), 32'd2);
    bus.req = '0;
    repeat (5) @(negedge clk);

    // round-robin from a clean rr_ptr; ack 2 -> enables 7 cycles apart
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 3'(i), 8'(8'h10 + i));
    ack_dly = 2;
    bus.req = 4'b1111;
    prev_e  = -1;
    for (int t = 0; t < 6; t++) begin
      wait_done(d, at);
      e = en_cyc_q[$];
      chk("rr_done", 32'(d), 32'(1 << (t % NR)));
      chk("rr_grant", 32'(en_grant_q[$]), 32'(1 << (t % NR)));
      if (t > 0) chk("rr_spacing", 32'(e - prev_e), 32'd7);
      prev_e = e;
      if (t < 5) begin
        bus.req = bus.req & ~d;
        @(negedge clk);
        bus.req = 4'b1111;
      end else begin
        bus.req = '0;
      end
    end
    repeat (8) @(negedge clk);

    // reset during WAIT: everything clears, no done pulse follows
    set_req(3, 1'b0, 3'd1, 8'h00);
    ack_dly = 0;
    bus.req = 4'b1000;
    en_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!en_seen) begin
        @(negedge clk);
        if (bus.m_enable) en_seen = 1'b1;
      end
    end
    chk("mid_enable_seen", 32'(en_seen), 32'd1);
    repeat (5) @(negedge clk);
    dc = done_cnt;
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check_zero("mid_rst");
    chk("mid_rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    reset = 1'b0;
    repeat (TO + 6) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'(dc));
    set_req(1, 1'b1, 3'd6, 8'h77);
    ack_dly = 4;
    bus.req = 4'b0010;
    wait_done(d, at);
    e = en_cyc_q[$];
    chk("post_rst_done", 32'(d), 32'h2);
    chk("post_rst_err", 32'(bus.err), 32'd0);
    chk("post_rst_lat", 32'(at - e), 32'd5);
    chk("post_rst_addr", 32'(last_addr), 32'd6);
    bus.req = '0;
    repeat (5) @(negedge clk);

    // ack lands exactly on the last timeout cycle: ack wins
    set_req(0, 1'b0, 3'd4, 8'h00);
    ack_dly = TO; ack_val = 8'h5A;
    bus.req = 4'b0001;
    wait_done(d, at);
    e = en_cyc_q[$];
    chk("coll_done", 32'(d), 32'h1);
    chk("coll_err", 32'(bus.err), 32'd0);
    chk("coll_rdata", 32'(bus.rdata), 32'h5A);
    chk("coll_lat", 32'(at - e), 32'(TO + 1));
    bus.req = '0;
    repeat (5) @(negedge clk);

    chk("enable_single_cycle", 32'(en_multi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
